apb_master_arbiter: RTL and testbench

APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

---
 rtl/shared_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/apb_master_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_apb_master_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_pkg.sv
// ============================================================================
//  Module : shared_pkg
//  Brief  : Shared types and default sizes for the APB master arbiter.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package shared_pkg;

    localparam int NO_REQ         = 2;
    localparam int DATA_WIDTH     = 32;
    localparam int ADDR_WIDTH     = 32;
    localparam int TIMEOUT_CYCLES = 16;

    // One-hot so each phase decodes from a single flop.
    typedef enum logic [2:0] {
        IDLE   = 3'b001,
        SETUP  = 3'b010,
        ACCESS = 3'b100
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
//  Module : rr_arbiter
//  Brief  : Round-robin selector. Requests at or above the pointer win first,
//           otherwise the search wraps to index 0. Output is one-hot.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NO_REQ = 2,
    parameter int PTR_W  = 1
) (
    input  logic [NO_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]  ptr_i,
    output logic [NO_REQ-1:0] grant_o
);

    logic [NO_REQ-1:0] masked;
    logic              found;

    // Keep only requests whose index is at or above the priority pointer.
    always_comb begin
        masked = '0;
        for (int i = 0; i < NO_REQ; i++) begin
            masked[i] = req_i[i] && (PTR_W'(i) >= ptr_i);
        end
    end

    // Lowest masked request wins; fall back to lowest raw request (wrap).
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NO_REQ; i++) begin
            if (!found && masked[i]) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
        for (int i = 0; i < NO_REQ; i++) begin
            if (!found && req_i[i]) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/apb_master_arbiter.sv
// ============================================================================
//  Module : apb_master_arbiter
//  Brief  : Shares one APB master port among NO_REQ requesters, round-robin,
//           with back-to-back transfers when a request waits at completion.
//           Optional macro APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES
//           cycles without PREADY (error response, zero read data).
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_master_arbiter #(
    parameter int NO_REQ     = shared_pkg::NO_REQ,
    parameter int DATA_WIDTH = shared_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = shared_pkg::ADDR_WIDTH
) (
    input  logic                         PCLK,
    input  logic                         PRESETn,
    input  logic [NO_REQ-1:0]            req_valid,
    input  logic [NO_REQ-1:0]            req_write,
    input  logic [NO_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NO_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NO_REQ-1:0]            req_ready,
    output logic [NO_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]        rsp_rdata,
    output logic                         rsp_slverr,
    output logic                         PSEL,
    output logic                         PENABLE,
    output logic                         PWRITE,
    output logic [ADDR_WIDTH-1:0]        PADDR,
    output logic [DATA_WIDTH-1:0]        PWDATA,
    input  logic [DATA_WIDTH-1:0]        PRDATA,
    input  logic                         PREADY,
    input  logic                         PSLVERR
);

    import shared_pkg::*;

    localparam int PTR_W = $clog2(NO_REQ);

    state_e                  state_q;
    logic [PTR_W-1:0]        ptr_q;
    logic [PTR_W-1:0]        ptr_d;
    logic [NO_REQ-1:0]       owner_q;
    logic                    pwrite_q;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic [DATA_WIDTH-1:0]   pwdata_q;
    logic                    psel_q;
    logic                    penable_q;
    logic [NO_REQ-1:0]       rsp_valid_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_slverr_q;

    logic                    xfer_done;
    logic                    arb_en;
    logic [NO_REQ-1:0]       req_elig;
    logic [NO_REQ-1:0]       grant;
    logic [PTR_W-1:0]        grant_idx;
    logic                    sel_write;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]        tmo_q;
    logic                    tmo_hit;
    assign tmo_hit = (state_q == ACCESS) && !PREADY
                     && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    // Arbitration is open while idle and in the completing ACCESS cycle, so a
    // waiting request goes straight to SETUP. Held off while in reset.
    assign xfer_done = (state_q == ACCESS) && PREADY;
    assign arb_en    = PRESETn && ((state_q == IDLE) || xfer_done);
    assign req_elig  = req_valid & {NO_REQ{arb_en}};

    rr_arbiter #(
        .NO_REQ (NO_REQ),
        .PTR_W  (PTR_W)
    ) u_rr_arbiter (
        .req_i   (req_elig),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    // Select the winning requester's fields and index.
    always_comb begin
        grant_idx = '0;
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NO_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = PTR_W'(i);
                sel_write = req_write[i];
                sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign ptr_d = (grant_idx == PTR_W'(NO_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);

    // APB phase FSM with registered bus outputs and response pulses.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            owner_q      <= '0;
            pwrite_q     <= 1'b0;
            paddr_q      <= '0;
            pwdata_q     <= '0;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_rdata_q  <= '0;
            rsp_slverr_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_q        <= '0;
`endif
        end else begin
            rsp_valid_q <= '0;
            if (|grant) begin
                owner_q  <= grant;
                pwrite_q <= sel_write;
                paddr_q  <= sel_addr;
                pwdata_q <= sel_wdata;
                ptr_q    <= ptr_d;
            end
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        state_q   <= SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
`ifdef APB_TIMEOUT_EN
                    tmo_q     <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid_q  <= owner_q;
                        rsp_slverr_q <= PSLVERR;
                        if (!pwrite_q) begin
                            rsp_rdata_q <= PRDATA;
                        end
                        penable_q <= 1'b0;
                        if (|grant) begin
                            state_q <= SETUP;
                            psel_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            psel_q  <= 1'b0;
                        end
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_hit) begin
                        rsp_valid_q  <= owner_q;
                        rsp_slverr_q <= 1'b1;
                        rsp_rdata_q  <= '0;
                        state_q      <= IDLE;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                default: begin
                    state_q   <= IDLE;
                    psel_q    <= 1'b0;
                    penable_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = grant;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign rsp_slverr = rsp_slverr_q;
    assign PSEL       = psel_q;
    assign PENABLE    = penable_q;
    assign PWRITE     = pwrite_q;
    assign PADDR      = paddr_q;
    assign PWDATA     = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// ============================================================================
//  Module : tb_apb_master_arbiter
//  Brief  : Self-checking bench: random requesters and completer against a
//           transfer-level reference model, plus directed scenarios.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_apb_master_arbiter;

    localparam int N   = 3;
    localparam int DW  = 32;
    localparam int AW  = 32;
    localparam int TMO = 16;

    logic            PCLK    = 1'b0;
    logic            PRESETn = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_write = '0;
    logic [N*AW-1:0] req_addr  = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_slverr;
    logic            PSEL, PENABLE, PWRITE;
    logic [AW-1:0]   PADDR;
    logic [DW-1:0]   PWDATA;
    logic [DW-1:0]   PRDATA  = '0;
    logic            PREADY  = 1'b0;
    logic            PSLVERR = 1'b0;

    apb_master_arbiter #(.NO_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // requester side
    logic [N-1:0]  rv = '0, rw = '0;
    logic [AW-1:0] ra [N];
    logic [DW-1:0] rd [N];
    // stimulus knobs
    logic [N-1:0]  gen_mask = '0;
    int gen_pct = 0, gen_budget = 0, ready_pct = 100, err_pct = 0, wd_pct = 0, wait_n = 0;
    bit wait_mode = 0, fix_en = 0, fix_w = 0, fix_prd_en = 0;
    logic [AW-1:0] fix_a = '0;
    logic [DW-1:0] fix_d = '0, fix_prd = '0;
    // reference model
    bit busy = 0, pend = 0, cur_w = 0, pend_err = 0;
    int cyc = 0, cur_own = 0, pend_own = 0, last = N-1;
    logic [AW-1:0] cur_a = '0;
    logic [DW-1:0] cur_d = '0, pend_rd = '0, rd_prev = '0;
    logic [N-1:0]  gnt_prev = '0;
    int q_grants [$];
    // observations
    int cycle = 0, acc_cnt = 0, grant_cyc = 0, rsp_cyc = 0;
    logic [N-1:0]  last_rsp_v = '0;
    bit            last_rsp_err = 0;
    logic [DW-1:0] last_rsp_rd = '0;

    function automatic int rr_pick(input logic [N-1:0] v, input int lst);
        for (int k = 1; k <= N; k++) begin
            if (v[(lst + k) % N]) return (lst + k) % N;
        end
        return -1;
    endfunction

    task automatic pack_reqs();
        for (int i = 0; i < N; i++) begin
            req_valid[i] = rv[i];
            req_write[i] = rw[i];
            req_addr[i*AW +: AW]  = ra[i];
            req_wdata[i*DW +: DW] = rd[i];
        end
    endtask

    task automatic model_reset();
        busy = 0; pend = 0; cyc = 0; last = N-1; rd_prev = '0; gnt_prev = '0;
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (gnt_prev[i]) rv[i] = 1'b0;
            else if (rv[i] && $urandom_range(99) < wd_pct) rv[i] = 1'b0;
            if (!rv[i] && gen_mask[i] && gen_budget != 0 && $urandom_range(99) < gen_pct) begin
                rv[i] = 1'b1;
                rw[i] = fix_en ? fix_w : 1'($urandom);
                ra[i] = fix_en ? fix_a : $urandom;
                rd[i] = fix_en ? fix_d : $urandom;
                if (gen_budget > 0) gen_budget--;
            end
        end
        gnt_prev = '0;
        pack_reqs();
        PREADY  = wait_mode ? (busy && cyc >= 2 && (cyc - 2) >= wait_n)
                            : ($urandom_range(99) < ready_pct);
        PRDATA  = fix_prd_en ? fix_prd : $urandom;
        PSLVERR = ($urandom_range(99) < err_pct);
    endtask

    task automatic check_and_update();
        logic [N-1:0] eg, ev;
        int  w;
        bit  can;
        check_val("PSEL", PSEL, busy);
        check_val("PENABLE", PENABLE, busy && cyc >= 2);
        if (busy) begin
            check_val("PADDR", PADDR, cur_a);
            check_val("PWRITE", PWRITE, cur_w);
            check_val("PWDATA", PWDATA, cur_d);
        end
        ev = pend ? (N'(1) << pend_own) : '0;
        check_val("rsp_valid", rsp_valid, ev);
        if (pend) begin
            check_val("rsp_slverr", rsp_slverr, pend_err);
            check_val("rsp_rdata", rsp_rdata, pend_rd);
        end
        if (rsp_valid != '0) begin
            last_rsp_v = rsp_valid; last_rsp_err = rsp_slverr; last_rsp_rd = rsp_rdata; rsp_cyc = cycle;
        end
        if (PENABLE) acc_cnt++;
        can = !busy || (cyc >= 2 && PREADY);
        eg = '0; w = -1;
        if (can && req_valid != '0) begin
            w  = rr_pick(req_valid, last);
            eg = N'(1) << w;
        end
        check_val("req_ready", req_ready, eg);
        // advance the model across the coming rising edge
        pend = 0;
        if (busy && cyc >= 2 && PREADY) begin
            pend = 1; pend_own = cur_own; pend_err = PSLVERR;
            if (!cur_w) rd_prev = PRDATA;
            pend_rd = rd_prev; busy = 0;
        end
`ifdef APB_TIMEOUT_EN
        else if (busy && cyc == TMO + 1 && !PREADY) begin
            pend = 1; pend_own = cur_own; pend_err = 1; rd_prev = '0; pend_rd = '0; busy = 0;
        end
`endif
        else if (busy) cyc++;
        if (w >= 0) begin
            busy = 1; cyc = 1; cur_own = w; cur_w = rw[w]; cur_a = ra[w]; cur_d = rd[w];
            last = w; q_grants.push_back(w); grant_cyc = cycle;
        end
        gnt_prev = eg;
    endtask

    task automatic step_body();
        drive_inputs();
        #1;
        check_and_update();
        cycle++;
    endtask

    task automatic step();
        @(negedge PCLK);
        step_body();
    endtask

    task automatic check_zero();
        check_val("rst PSEL", PSEL, 0);
        check_val("rst PENABLE", PENABLE, 0);
        check_val("rst PWRITE", PWRITE, 0);
        check_val("rst PADDR", PADDR, 0);
        check_val("rst PWDATA", PWDATA, 0);
        check_val("rst req_ready", req_ready, 0);
        check_val("rst rsp_valid", rsp_valid, 0);
        check_val("rst rsp_rdata", rsp_rdata, 0);
        check_val("rst rsp_slverr", rsp_slverr, 0);
    endtask

    // Asynchronous reset asserted mid-cycle; released on a falling edge.
    task automatic do_reset(input bit clear);
        #2 PRESETn = 1'b0;
        if (clear) begin
            rv = '0;
            pack_reqs();
        end
        #1 check_zero();
        model_reset();
        q_grants.delete();
        repeat (2) @(negedge PCLK);
        PRESETn = 1'b1;
        step_body();
    endtask

    task automatic wait_idle(input int max, input string tag);
        int k = 0;
        while ((busy || pend || rv != '0) && k < max) begin
            step();
            k++;
        end
        check_val(tag, k < max, 1);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        do_reset(1);

        // single write, zero wait states
        gen_mask = 3'b001; gen_budget = 1; gen_pct = 100; ready_pct = 100; err_pct = 0;
        fix_en = 1; fix_w = 1; fix_a = 32'h10; fix_d = 32'hDEAD_BEEF;
        last_rsp_v = '0;
        step();
        gen_mask = '0;
        wait_idle(20, "T1 drain");
        check_val("T1 latency", rsp_cyc - grant_cyc, 3);
        check_val("T1 owner", last_rsp_v, 3'b001);
        check_val("T1 slverr", last_rsp_err, 0);

        // two requesters always valid from reset: alternate, back to back
        fix_en = 0;
        do_reset(1);
        gen_mask = 3'b011; gen_budget = -1;
        for (int k = 0; k < 40 && q_grants.size() < 4; k++) step();
        gen_mask = '0;
        wait_idle(40, "T2 drain");
        for (int k = 0; k < 4; k++)
            check_val("T2 order", (q_grants.size() > k) ? q_grants[k] : -1, k % 2);

        // read with three wait states
        gen_mask = 3'b001; gen_budget = 1; fix_en = 1; fix_w = 0; fix_a = 32'h20;
        wait_mode = 1; wait_n = 3; fix_prd_en = 1; fix_prd = 32'h1234_5678;
        acc_cnt = 0;
        step();
        gen_mask = '0;
        wait_idle(30, "T3 drain");
        check_val("T3 access cycles", acc_cnt, 4);
        check_val("T3 rdata", last_rsp_rd, 32'h1234_5678);
        wait_mode = 0; fix_prd_en = 0;

        // slave error on a write from requester 1
        gen_mask = 3'b010; gen_budget = 1; fix_w = 1; fix_a = 32'h44; fix_d = 32'h5A5A_0001;
        err_pct = 100; last_rsp_v = '0;
        step();
        gen_mask = '0;
        wait_idle(20, "T4 drain");
        check_val("T4 owner", last_rsp_v, 3'b010);
        check_val("T4 slverr", last_rsp_err, 1);
        err_pct = 0; fix_en = 0;

        // reset while requester 0 sits in ACCESS
        gen_mask = 3'b011; gen_budget = -1; wait_mode = 1; wait_n = 1000;
        for (int k = 0; k < 20 && !(busy && cyc >= 3); k++) step();
        check_val("T5 reached access", busy && cyc >= 3 && cur_own == 0, 1);
        wait_mode = 0; ready_pct = 100;
        do_reset(0);
        check_val("T5 first grant", (q_grants.size() > 0) ? q_grants[0] : -1, 0);
        gen_mask = '0;
        wait_idle(40, "T5 drain");

        // randomized traffic
        gen_mask = 3'b111; gen_budget = -1; gen_pct = 40; ready_pct = 60; err_pct = 20; wd_pct = 5;
        for (int k = 0; k < 1500; k++) step();
        gen_mask = '0; wd_pct = 0; ready_pct = 100;
        wait_idle(200, "T6 drain");

`ifdef APB_TIMEOUT_EN
        // completer never ready: abort with error
        err_pct = 0; gen_pct = 100;
        gen_mask = 3'b001; gen_budget = 1; fix_en = 1; fix_w = 0; fix_a = 32'h80;
        wait_mode = 1; wait_n = 1000; acc_cnt = 0;
        step();
        gen_mask = '0;
        wait_idle(60, "T7 drain");
        check_val("T7 access cycles", acc_cnt, TMO);
        check_val("T7 slverr", last_rsp_err, 1);
        check_val("T7 rdata", last_rsp_rd, 0);
        wait_mode = 0; fix_en = 0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire
